// File: rtl/pavana_ooo_slave_tagged_if.sv
// Bus bundle between the OoO crossbar slave port and a tagged memory slave.
// The crossbar side drives requests; the slave answers with acks and tagged responses.
interface pavana_ooo_slave_tagged_if #(
  parameter int TAG_WIDTH = 2
);
  logic                 req_i;
  logic [31:0]          addr_bi;
  logic                 cmd_i;
  logic [31:0]          wdata_bi;
  logic                 ack_o;
  logic [TAG_WIDTH-1:0] reqtid_o;
  logic                 resp_o;
  logic [TAG_WIDTH-1:0] resptid_o;
  logic [31:0]          rdata_bo;

  modport master (
    output req_i, addr_bi, cmd_i, wdata_bi,
    input  ack_o, reqtid_o, resp_o, resptid_o, rdata_bo
  );

  modport slave (
    input  req_i, addr_bi, cmd_i, wdata_bi,
    output ack_o, reqtid_o, resp_o, resptid_o, rdata_bo
  );
endinterface

// File: rtl/pavana_ooo_slave_tagged.sv
// Tagged out-of-order memory slave.
// Each acked read takes the lowest free tag, snapshots the memory word, and
// counts down a per-address latency; ready tags answer one per cycle, lowest
// tag first, so responses come back out of order on resp_o/resptid_o.
module pavana_ooo_slave_tagged #(
  parameter int TAG_WIDTH      = 2,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int LAT_SHORT      = 2,
  parameter int LAT_LONG       = 9,
  parameter int LAT_SEL_BIT    = 2
) (
  input logic clk_i,
  input logic rst_i,
  pavana_ooo_slave_tagged_if.slave bus
);

  localparam int NTAG      = 1 << TAG_WIDTH;
  localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [NTAG-1:0]           busy;
  logic [3:0]                cnt    [NTAG];
  logic [31:0]               data_q [NTAG];
  logic [31:0]               mem    [MEM_DEPTH];

  logic [MEM_ADDR_WIDTH-1:0] word;
  logic                      free_avail;
  logic [TAG_WIDTH-1:0]      ffree;
  logic [NTAG-1:0]           ready;
  logic                      any_ready;
  logic [TAG_WIDTH-1:0]      rsel;
  logic                      ack;
  logic                      rd_ack;
  logic                      wr_ack;
  logic [3:0]                lat_load;

  logic                      resp_q;
  logic [TAG_WIDTH-1:0]      resptid_q;
  logic [31:0]               rdata_q;

  logic                      unused_addr;

  assign word        = bus.addr_bi[MEM_ADDR_WIDTH+1:2];
  assign unused_addr = ^{bus.addr_bi[31:MEM_ADDR_WIDTH+2], bus.addr_bi[1:0]};

  // Lowest-index free tag, taken from the busy state at the start of the cycle.
  always_comb begin
    free_avail = ~&busy;
    ffree      = '0;
    for (int t = NTAG - 1; t >= 0; t--) begin
      if (!busy[t]) ffree = TAG_WIDTH'(t);
    end
  end

  // Ready tags are busy with an expired countdown; the lowest one is answered.
  always_comb begin
    any_ready = 1'b0;
    rsel      = '0;
    ready     = '0;
    for (int t = NTAG - 1; t >= 0; t--) begin
      ready[t] = busy[t] && (cnt[t] == 4'd0);
      if (ready[t]) begin
        any_ready = 1'b1;
        rsel      = TAG_WIDTH'(t);
      end
    end
  end

  // Writes never need a tag; reads need one free entry. Nothing is acked in reset.
  assign ack    = bus.req_i & ~rst_i & (bus.cmd_i | free_avail);
  assign rd_ack = ack & ~bus.cmd_i;
  assign wr_ack = ack & bus.cmd_i;

  // The ack cycle itself counts as the first latency cycle, so the counter is
  // loaded one short; a read acked in cycle c is then selected in c+L and its
  // response is visible in c+L+1.
  assign lat_load = bus.addr_bi[LAT_SEL_BIT] ? 4'(LAT_LONG - 1) : 4'(LAT_SHORT - 1);

  assign bus.ack_o     = ack;
  assign bus.reqtid_o  = free_avail ? ffree : '0;
  assign bus.resp_o    = resp_q;
  assign bus.resptid_o = resptid_q;
  assign bus.rdata_bo  = rdata_q;

  // Memory array: written at the end of an acked write, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_ack) mem[word] <= bus.wdata_bi;
  end

  // Read data is snapshotted into the tag at ack so later writes cannot alter it.
  always_ff @(posedge clk_i) begin
    if (rd_ack) data_q[ffree] <= mem[word];
  end

  // Tag bookkeeping: countdown, release of the answered tag, allocation of a new one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= '0;
      for (int t = 0; t < NTAG; t++) cnt[t] <= 4'd0;
    end else begin
      for (int t = 0; t < NTAG; t++) begin
        if (busy[t] && (cnt[t] != 4'd0)) cnt[t] <= cnt[t] - 4'd1;
      end
      if (any_ready) busy[rsel] <= 1'b0;
      if (rd_ack) begin
        busy[ffree] <= 1'b1;
        cnt[ffree]  <= lat_load;
      end
    end
  end

  // Response register: one tagged response per cycle; tag and data hold when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q    <= 1'b0;
      resptid_q <= '0;
      rdata_q   <= '0;
    end else begin
      resp_q <= any_ready;
      if (any_ready) begin
        resptid_q <= rsel;
        rdata_q   <= data_q[rsel];
      end
    end
  end

endmodule

// File: tb/tb_pavana_ooo_slave_tagged.sv
// Self-checking bench for the tagged out-of-order memory slave.
// A cycle-stamped model of outstanding reads predicts every output each cycle;
// directed scenarios add hand-computed literal expectations on top.
module tb_pavana_ooo_slave_tagged;

  localparam int TAG_WIDTH = 2;
  localparam int NTAG      = 4;
  localparam int LAT_SHORT = 2;
  localparam int LAT_LONG  = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;

  // Model state: tag ownership with the absolute cycle each read becomes ready.
  logic                 mBusy    [NTAG];
  int                   mReadyAt [NTAG];
  logic [31:0]          mData    [NTAG];
  logic [31:0]          memModel [256];
  logic                 expResp;
  logic [TAG_WIDTH-1:0] expTid;
  logic [31:0]          expRdata;
  bit                   freeAvail;
  int                   freeTag;
  int                   pick;
  bit                   expAck;

  int  waits;
  bit  acked;

  pavana_ooo_slave_tagged_if #(.TAG_WIDTH(TAG_WIDTH)) bus ();

  pavana_ooo_slave_tagged #(
    .TAG_WIDTH     (TAG_WIDTH),
    .MEM_ADDR_WIDTH(8),
    .LAT_SHORT     (LAT_SHORT),
    .LAT_LONG      (LAT_LONG),
    .LAT_SEL_BIT   (2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One comparison; a mismatch prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Drives one cycle of inputs and returns just after the falling edge of that cycle.
  task automatic applyStimulus(input logic req, input logic cmd, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    bus.req_i    = req;
    bus.cmd_i    = cmd;
    bus.addr_bi  = addr;
    bus.wdata_bi = wdata;
    @(negedge clk);
    #1;
  endtask

  // Cycle-by-cycle compare against the model, then advance the model past the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("reset_ack", bus.ack_o, 32'd0);
        checkOutput("reset_resp", bus.resp_o, 32'd0);
        checkOutput("reset_resptid", bus.resptid_o, 32'd0);
        checkOutput("reset_rdata", bus.rdata_bo, 32'd0);
        for (int t = 0; t < NTAG; t++) mBusy[t] = 1'b0;
        expResp  = 1'b0;
        expTid   = '0;
        expRdata = '0;
      end else begin
        freeAvail = 1'b0;
        freeTag   = 0;
        for (int t = NTAG - 1; t >= 0; t--) begin
          if (!mBusy[t]) begin
            freeAvail = 1'b1;
            freeTag   = t;
          end
        end
        expAck = bus.req_i && (bus.cmd_i || freeAvail);
        checkOutput("ack", bus.ack_o, 32'(expAck));
        checkOutput("reqtid", bus.reqtid_o, 32'(freeTag));
        checkOutput("resp", bus.resp_o, 32'(expResp));
        checkOutput("resptid", bus.resptid_o, 32'(expTid));
        checkOutput("rdata", bus.rdata_bo, expRdata);

        pick = -1;
        for (int t = NTAG - 1; t >= 0; t--) begin
          if (mBusy[t] && (cyc >= mReadyAt[t])) pick = t;
        end
        if (pick >= 0) begin
          expResp     = 1'b1;
          expTid      = TAG_WIDTH'(pick);
          expRdata    = mData[pick];
          mBusy[pick] = 1'b0;
        end else begin
          expResp = 1'b0;
        end

        if (expAck && bus.cmd_i) begin
          memModel[bus.addr_bi[9:2]] = bus.wdata_bi;
        end else if (expAck) begin
          mBusy[freeTag]    = 1'b1;
          mReadyAt[freeTag] = cyc + (bus.addr_bi[2] ? LAT_LONG : LAT_SHORT);
          mData[freeTag]    = memModel[bus.addr_bi[9:2]];
        end
      end
      cyc++;
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    bus.req_i    = 1'b0;
    bus.cmd_i    = 1'b0;
    bus.addr_bi  = '0;
    bus.wdata_bi = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload every word with a known pattern.
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b1, 32'(i) << 2, 32'hC0DE_0000 + 32'(i));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // Write then read-after-write, short latency.
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("t1_wr_ack", bus.ack_o, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("t1_rd_ack", bus.ack_o, 32'd1);
    checkOutput("t1_reqtid", bus.reqtid_o, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 3) begin
        checkOutput("t1_resp", bus.resp_o, 32'd1);
        checkOutput("t1_resptid", bus.resptid_o, 32'd0);
        checkOutput("t1_rdata", bus.rdata_bo, 32'hDEAD_BEEF);
      end else begin
        checkOutput("t1_quiet", bus.resp_o, 32'd0);
      end
    end

    // Long read then short read: responses return out of order.
    applyStimulus(1'b1, 1'b0, 32'h04, 32'h0);
    checkOutput("t2_tag0", bus.reqtid_o, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h08, 32'h0);
    checkOutput("t2_tag1", bus.reqtid_o, 32'd1);
    for (int k = 2; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 4) begin
        checkOutput("t2_first_resp", bus.resp_o, 32'd1);
        checkOutput("t2_first_tid", bus.resptid_o, 32'd1);
        checkOutput("t2_first_data", bus.rdata_bo, 32'hC0DE_0002);
      end else if (k == 10) begin
        checkOutput("t2_second_resp", bus.resp_o, 32'd1);
        checkOutput("t2_second_tid", bus.resptid_o, 32'd0);
        checkOutput("t2_second_data", bus.rdata_bo, 32'hC0DE_0001);
      end else begin
        checkOutput("t2_quiet", bus.resp_o, 32'd0);
      end
    end

    // Fill all tags, write while full, then hold a fifth read until a tag frees.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h04 + 32'(i) * 32'h10, 32'h0);
      checkOutput("t3_fill_tag", bus.reqtid_o, 32'(i));
    end
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h1234_5678);
    checkOutput("t3_write_when_full", bus.ack_o, 32'd1);
    waits = 0;
    acked = 1'b0;
    while (!acked && waits < 20) begin
      applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
      if (bus.ack_o) acked = 1'b1;
      else waits++;
    end
    checkOutput("t3_wait_cycles", 32'(waits), 32'd5);
    checkOutput("t3_late_tag", bus.reqtid_o, 32'd0);
    checkOutput("t3_resp_same_cycle", bus.resp_o, 32'd1);
    checkOutput("t3_resp_tid", bus.resptid_o, 32'd0);
    repeat (25) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // Two reads becoming ready together: lowest tag first, back to back.
    applyStimulus(1'b1, 1'b0, 32'h04, 32'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h08, 32'h0);
    checkOutput("t4_tag1", bus.reqtid_o, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 3) begin
        checkOutput("t4_resp_a", bus.resp_o, 32'd1);
        checkOutput("t4_tid_a", bus.resptid_o, 32'd0);
      end else if (k == 4) begin
        checkOutput("t4_resp_b", bus.resp_o, 32'd1);
        checkOutput("t4_tid_b", bus.resptid_o, 32'd1);
      end else begin
        checkOutput("t4_quiet", bus.resp_o, 32'd0);
      end
    end

    // Read snapshot is not disturbed by a following write; a later read sees it.
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t5_old_resp", bus.resp_o, 32'd1);
    checkOutput("t5_old_data", bus.rdata_bo, 32'hC0DE_0008);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t5_new_resp", bus.resp_o, 32'd1);
    checkOutput("t5_new_data", bus.rdata_bo, 32'h1);

    // Reset mid-countdown drops outstanding reads.
    applyStimulus(1'b1, 1'b0, 32'h04, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.req_i    = 1'b1;
    bus.cmd_i    = 1'b1;
    bus.addr_bi  = 32'h04;
    bus.wdata_bi = 32'h0BAD;
    @(negedge clk);
    #1;
    checkOutput("t6_ack_in_reset", bus.ack_o, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.req_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("t6_no_resp", bus.resp_o, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h04, 32'h0);
    checkOutput("t6_ack_after", bus.ack_o, 32'd1);
    checkOutput("t6_tag_after", bus.reqtid_o, 32'd0);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
